// File: rtl/program_loader.sv
// program_loader: turns a serial byte stream (count, 6-byte instructions,
// XOR checksum) into program-memory writes, holding the CPU in reset until
// the whole image has arrived with a good checksum.
// Latency: one WRITE cycle per instruction after its 6th byte; done/error one
// cycle after the checksum byte. Backpressure: byte_ready low in WRITE/DONE/ERROR.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   byte_in/byte_valid/byte_ready  load stream, transfer when valid & ready
//   prog_we/prog_addr          one-cycle write strobe and word index
//   prog_opcode/operand/data   assembled instruction fields (held between writes)
//   cpu_hold                   processor reset, released only on a good load
//   load_done/load_error       sticky completion status
//   word_count                 words written so far in this load
module program_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_opcode,
    output logic [DATA_WIDTH-1:0] prog_operand,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           word_count
);

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        BODY,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [7:0]            cnt_hi_q;
    logic [15:0]           n_q;
    logic [2:0]            pos_q;
    logic [7:0]            stg_q [0:4];
    logic [7:0]            xor_q;
    logic [15:0]           word_cnt_q;

    logic                  byte_ready_q;
    logic                  prog_we_q;
    logic [ADDR_WIDTH-1:0] prog_addr_q;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cpu_hold_q;
    logic                  load_done_q;
    logic                  load_error_q;

    logic                  accept;
    logic                  last_word;

    // byte_ready_q is registered from the next state, so it always matches
    // the current state except while in reset (where it is forced low).
    assign accept    = byte_valid && byte_ready_q;
    assign last_word = (word_cnt_q == n_q - 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_HI: if (accept) state_d = CNT_LO;
            CNT_LO: if (accept) state_d = ({cnt_hi_q, byte_in} != 16'd0) ? BODY : CHECK;
            BODY:   if (accept && pos_q == 3'd5) state_d = WRITE;
            WRITE:  state_d = last_word ? CHECK : BODY;
            CHECK:  if (accept) state_d = (byte_in == xor_q) ? DONE : ERROR;
            DONE:   state_d = DONE;
            ERROR:  state_d = ERROR;
            default: state_d = CNT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CNT_HI;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            pos_q        <= '0;
            for (int i = 0; i < 5; i++) stg_q[i] <= '0;
            xor_q        <= '0;
            word_cnt_q   <= '0;
            byte_ready_q <= 1'b0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= '0;
            opcode_q     <= '0;
            operand_q    <= '0;
            data_q       <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_we_q <= 1'b0;

            case (state_q)
                CNT_HI: begin
                    if (accept) begin
                        cnt_hi_q <= byte_in;
                        xor_q    <= xor_q ^ byte_in;
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        n_q   <= {cnt_hi_q, byte_in};
                        xor_q <= xor_q ^ byte_in;
                        pos_q <= '0;
                    end
                end
                BODY: begin
                    if (accept) begin
                        xor_q <= xor_q ^ byte_in;
                        if (pos_q == 3'd5) begin
                            // Last byte of the instruction: publish all three
                            // fields together so they are stable for the strobe.
                            pos_q       <= '0;
                            prog_we_q   <= 1'b1;
                            prog_addr_q <= ADDR_WIDTH'(word_cnt_q);
                            opcode_q    <= DATA_WIDTH'({stg_q[0], stg_q[1]});
                            operand_q   <= DATA_WIDTH'({stg_q[2], stg_q[3]});
                            data_q      <= DATA_WIDTH'({stg_q[4], byte_in});
                        end else begin
                            stg_q[pos_q] <= byte_in;
                            pos_q        <= pos_q + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    word_cnt_q <= word_cnt_q + 16'd1;
                end
                default: ;
            endcase

            byte_ready_q <= (state_d == CNT_HI) || (state_d == CNT_LO) ||
                            (state_d == BODY)   || (state_d == CHECK);
            cpu_hold_q   <= (state_d != DONE);
            load_done_q  <= (state_d == DONE);
            load_error_q <= (state_d == ERROR);
        end
    end

    assign byte_ready   = byte_ready_q;
    assign prog_we      = prog_we_q;
    assign prog_addr    = prog_addr_q;
    assign prog_opcode  = opcode_q;
    assign prog_operand = operand_q;
    assign prog_data    = data_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign word_count   = word_cnt_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each instruction field (opcode, operand, data).
REQ-002 Parameter ADDR_WIDTH, default 16, width of the program-memory write address.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 byte_in  input  8  serial load stream byte.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle; transfer occurs only when byte_valid and byte_ready are both 1.
REQ-008 prog_we  output  1  one-cycle write strobe to program memory.
REQ-009 prog_addr  output  ADDR_WIDTH  instruction word index for the write.
REQ-010 prog_opcode, prog_operand, prog_data  output  DATA_WIDTH each  assembled instruction fields.
REQ-011 cpu_hold  output  1  holds the processor in reset while high.
REQ-012 load_done  output  1  load completed with a good checksum.
REQ-013 load_error  output  1  load aborted on a checksum mismatch.
REQ-014 word_count  output  16  number of words written so far.

Function
REQ-015 The stream format SHALL be: count N, 2 bytes, big-endian; then N instructions of 6 bytes each (opcode hi, opcode lo, operand hi, operand lo, data hi, data lo); then 1 checksum byte.
REQ-016 The checksum byte SHALL equal the XOR of every preceding byte in the stream, header included.
REQ-017 The FSM states SHALL be CNT_HI, CNT_LO, BODY, WRITE, CHECK, DONE, ERROR.
REQ-018 byte_ready SHALL be 1 in CNT_HI, CNT_LO, BODY and CHECK, and 0 in WRITE, DONE and ERROR.
REQ-019 State transitions SHALL be:
- CNT_HI -> CNT_LO on an accepted byte.
- CNT_LO -> BODY on an accepted byte if N != 0; CNT_LO -> CHECK if N == 0.
- BODY -> WRITE after the 6th accepted byte of the instruction.
- WRITE -> BODY after one cycle, or WRITE -> CHECK when the written index equals N-1.
- CHECK -> DONE on a match; CHECK -> ERROR on a mismatch.
REQ-020 BODY SHALL track the byte position with a 0..5 counter that wraps to 0 on entry to WRITE.
REQ-021 In WRITE, prog_we SHALL be 1 for exactly one cycle with prog_addr = current index and all three fields stable.
REQ-022 The index and word_count SHALL increment on the clock edge that ends WRITE.
REQ-023 prog_addr SHALL hold its last value when prog_we = 0; the field outputs SHALL hold the last assembled values.
REQ-024 The running XOR SHALL update on every accepted byte except the checksum byte itself.
REQ-025 DONE: cpu_hold = 0, load_done = 1. ERROR: cpu_hold = 1, load_error = 1. Both states are sticky until reset.
REQ-026 Bytes presented while byte_ready = 0 SHALL NOT be consumed and SHALL NOT alter the checksum.
REQ-027 byte_valid deasserting mid-instruction SHALL stall the FSM without losing the partial field contents.
REQ-028 An N larger than 2^ADDR_WIDTH SHALL wrap prog_addr modulo 2^ADDR_WIDTH; word_count SHALL still count to N.

Reset
REQ-029 While reset is high, state SHALL be CNT_HI and the outputs SHALL be: cpu_hold = 1, byte_ready = 0, prog_we = 0, load_done = 0, load_error = 0, prog_addr = 0, all fields = 0, word_count = 0, running XOR = 0.
REQ-030 byte_ready SHALL rise on the first clock edge after reset deasserts.
REQ-031 Reset asserted mid-load SHALL abort immediately; the memory contents already written SHALL be left untouched.

Verification
REQ-032 Stream 00 01 22 00 00 03 00 00 20 -> one prog_we with addr 0, opcode 0x2200, operand 0x0003, data 0x0000; then load_done = 1, cpu_hold = 0, word_count = 1.
REQ-033 Same stream with checksum 21 -> load_error = 1, cpu_hold stays 1, load_done = 0.
REQ-034 Stream 00 00 00 -> no prog_we, DONE reached, word_count = 0.
REQ-035 N = 3 with byte_valid toggled every other cycle -> three writes at addresses 0, 1, 2 with correct fields; byte_ready = 0 in each WRITE cycle; no byte dropped.
REQ-036 Reset pulsed after the 4th body byte, then a full valid stream sent -> the load restarts from CNT_HI and the first write lands at addr 0.
REQ-037 Extra bytes presented after DONE -> byte_ready = 0, outputs unchanged.
